// File: rtl/aidc_lite_decomp_cfg_mq_if.sv
// APB3 register-port bundle for the decompressor config block.
interface apb_intf;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/aidc_lite_decomp_cfg_mq.sv
// Multi-channel decompressor config/status: per-channel staging regs, descriptor
// queues drained by valid/ready, outstanding tracking, done counters and IRQ.
module aidc_lite_decomp_cfg_mq #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned Q_DEPTH = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  apb_intf.slave                   apb_if,
  output logic [NUM_CH-1:0]        desc_valid_o,
  input  logic [NUM_CH-1:0]        desc_ready_i,
  output logic [NUM_CH-1:0][31:0]  desc_src_o,
  output logic [NUM_CH-1:0][31:0]  desc_dst_o,
  output logic [NUM_CH-1:0][25:0]  desc_len_o,
  input  logic [NUM_CH-1:0]        done_i,
  output logic                     irq_o
);

  localparam int unsigned PTR_W  = $clog2(Q_DEPTH);
  localparam int unsigned QCNT_W = $clog2(Q_DEPTH + 1);
  localparam int unsigned OUT_W  = QCNT_W + 1;
  localparam logic [QCNT_W-1:0] Q_FULL = QCNT_W'(Q_DEPTH);

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [25:0] len;
  } desc_t;

  logic [3:0]        ch_idx;
  logic [3:0]        reg_idx;
  logic              ch_ok;
  logic              wr_cmt;
  logic              rd_cap;
  logic [31:0]       rd_ch [NUM_CH];
  logic [31:0]       rd_mux;
  logic [31:0]       prdata_q;
  logic [NUM_CH-1:0] irq_vec;

  assign ch_idx  = apb_if.paddr[9:6];
  assign reg_idx = apb_if.paddr[5:2];
  assign ch_ok   = ({1'b0, ch_idx} < 5'(NUM_CH));
  assign wr_cmt  = apb_if.psel & apb_if.penable & apb_if.pwrite & ch_ok;
  assign rd_cap  = apb_if.psel & ~apb_if.penable & ~apb_if.pwrite;

  wire unused_paddr = &{1'b0, apb_if.paddr[31:10], apb_if.paddr[1:0]};

  assign apb_if.pready  = 1'b1;
  assign apb_if.pslverr = apb_if.psel & apb_if.penable & ~ch_ok;
  assign apb_if.prdata  = prdata_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [31:0]       src_q;
    logic [31:0]       dst_q;
    logic [25:0]       len_q;
    desc_t             mem [Q_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [QCNT_W-1:0] count;
    logic [OUT_W-1:0]  outst;
    logic [CNT_W-1:0]  done_cnt;
    logic [1:0]        int_st;
    logic [1:0]        int_en;
    logic              sel, doorbell, full, empty, push, pop, done_ok, busy;
    logic [1:0]        w1c;

    assign sel      = wr_cmt && (ch_idx == 4'(c));
    assign doorbell = sel && (reg_idx == 4'd3) && apb_if.pwdata[0];
    assign full     = (count == Q_FULL);
    assign empty    = (count == '0);
    // Full is judged on the pre-pop count, so a doorbell into a full queue drops
    assign push     = doorbell && !full;
    assign pop      = !empty && desc_ready_i[c];
    assign done_ok  = done_i[c] && (outst != '0);
    assign busy     = !empty || (outst != '0);
    assign w1c      = (sel && (reg_idx == 4'd6)) ? apb_if.pwdata[1:0] : 2'b00;

    assign desc_valid_o[c] = !empty;
    assign desc_src_o[c]   = mem[rd_ptr].src;
    assign desc_dst_o[c]   = mem[rd_ptr].dst;
    assign desc_len_o[c]   = mem[rd_ptr].len;
    assign irq_vec[c]      = |(int_st & int_en);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        src_q    <= '0;
        dst_q    <= '0;
        len_q    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        outst    <= '0;
        done_cnt <= '0;
        int_st   <= '0;
        int_en   <= '0;
        for (int i = 0; i < Q_DEPTH; i++) mem[i] <= '0;
      end else begin
        if (sel && reg_idx == 4'd0) src_q  <= apb_if.pwdata;
        if (sel && reg_idx == 4'd1) dst_q  <= apb_if.pwdata;
        if (sel && reg_idx == 4'd2) len_q  <= apb_if.pwdata[31:6];
        if (sel && reg_idx == 4'd7) int_en <= apb_if.pwdata[1:0];
        if (push) begin
          mem[wr_ptr] <= '{src: src_q, dst: dst_q, len: len_q};
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + QCNT_W'(push) - QCNT_W'(pop);
        if (pop && !done_ok)      outst <= outst + 1'b1;
        else if (done_ok && !pop) outst <= outst - 1'b1;
        // A completion landing on the clearing write still counts
        if (done_ok)
          done_cnt <= (sel && reg_idx == 4'd5) ? CNT_W'(1)
                    : ((done_cnt == '1) ? done_cnt : done_cnt + 1'b1);
        else if (sel && reg_idx == 4'd5)
          done_cnt <= '0;
        int_st <= (int_st & ~w1c) | {doorbell && full, done_ok};
      end
    end

    always_comb begin
      rd_ch[c] = '0;
      case (reg_idx)
        4'd0: rd_ch[c] = src_q;
        4'd1: rd_ch[c] = dst_q;
        4'd2: rd_ch[c] = {len_q, 6'd0};
        4'd4: rd_ch[c] = {8'd0, 8'(outst), 8'(count), 5'd0, full, empty, busy};
        4'd5: rd_ch[c] = 32'(done_cnt);
        4'd6: rd_ch[c] = {30'd0, int_st};
        4'd7: rd_ch[c] = {30'd0, int_en};
        default: rd_ch[c] = '0;
      endcase
    end
  end

  // Channel select for readback; out-of-range channels read 0
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (ch_idx == 4'(c)) rd_mux = rd_ch[c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata_q <= '0;
      irq_o    <= 1'b0;
    end else begin
      if (rd_cap) prdata_q <= ch_ok ? rd_mux : 32'd0;
      irq_o <= |irq_vec;
    end
  end

endmodule
